// File: rtl/scm_1r1w_rr_arbiter_pkg.sv
// Shared types and helpers for the 1R/1W SCM arbiter: index width function and
// the pointer/index type used by every round-robin instance.
package scm_arb_pkg;

  localparam int unsigned MAX_MASTERS = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RR_IDX_W = idx_width(MAX_MASTERS);

  typedef logic [RR_IDX_W-1:0] rr_ptr_t;

endpackage

// File: rtl/register_file_1r_1w_be.sv
// 1-read/1-write register file with per-byte write enables; read data is
// registered and holds its value while ReadEnable is low.
module register_file_1r_1w_be #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [NUM_BYTE-1:0]   WriteBE
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read samples the pre-write contents, so a same-cycle write is not bypassed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (ReadEnable) r_rdata <= r_mem[ReadAddr];
      if (WriteEnable) begin
        for (int unsigned b = 0; b < NUM_BYTE; b++) begin
          if (WriteBE[b]) r_mem[WriteAddr][b*8 +: 8] <= WriteData[b*8 +: 8];
        end
      end
    end
  end

  assign ReadData = r_rdata;

endmodule

// File: rtl/scm_rr_arbiter.sv
// Single-class round-robin arbiter: grants the first requester at or after its
// pointer (with wrap-around) and moves the pointer past the winner.
module scm_rr_arbiter
  import scm_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [NB_MASTERS-1:0] i_req,
  output logic [NB_MASTERS-1:0] o_gnt_c,
  output rr_ptr_t               o_idx_c,
  output logic                  o_valid_c
);

  rr_ptr_t r_ptr;
  rr_ptr_t w_ptr_nxt;
  logic    w_hit;

  // First pass covers indices at/after the pointer, second pass the wrapped ones.
  always_comb begin
    w_hit   = 1'b0;
    o_idx_c = '0;
    o_gnt_c = '0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      if (!w_hit && i_req[k] && (rr_ptr_t'(k) >= r_ptr)) begin
        w_hit   = 1'b1;
        o_idx_c = rr_ptr_t'(k);
      end
    end
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      if (!w_hit && i_req[k]) begin
        w_hit   = 1'b1;
        o_idx_c = rr_ptr_t'(k);
      end
    end
    if (!i_en) w_hit = 1'b0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      o_gnt_c[k] = w_hit && (o_idx_c == rr_ptr_t'(k));
    end
    o_valid_c = w_hit;
  end

  assign w_ptr_nxt = (o_idx_c == rr_ptr_t'(NB_MASTERS - 1)) ? '0 : o_idx_c + rr_ptr_t'(1);

  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= '0;
    else if (w_hit) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/scm_1r1w_rr_arbiter.sv
// Shares one 1R/1W byte-enable register file between NB_MASTERS requesters with
// independent round-robin arbitration of the read and write ports.
module scm_1r1w_rr_arbiter
  import scm_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NB_MASTERS-1:0]                 req_i,
  input  logic [NB_MASTERS-1:0]                 we_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NB_MASTERS-1:0][NUM_BYTE-1:0]   be_i,
  output logic [NB_MASTERS-1:0]                 gnt_o,
  output logic [NB_MASTERS-1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o
);

  logic [NB_MASTERS-1:0] w_rreq, w_wreq, w_rgnt, w_wgnt;
  rr_ptr_t               w_ridx, w_widx;
  logic                  w_rvld, w_wvld;
  logic [ADDR_WIDTH-1:0] w_raddr, w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_rdata;
  logic [NUM_BYTE-1:0]   w_wbe;
  logic                  w_rst_n;

  logic                  r_rvld;
  rr_ptr_t               r_ridx;

  assign w_rreq  = req_i & ~we_i;
  assign w_wreq  = req_i & we_i;
  assign w_rst_n = ~rst;

  scm_rr_arbiter #(.NB_MASTERS(NB_MASTERS)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_rst_n),
    .i_req     (w_rreq),
    .o_gnt_c   (w_rgnt),
    .o_idx_c   (w_ridx),
    .o_valid_c (w_rvld)
  );

  scm_rr_arbiter #(.NB_MASTERS(NB_MASTERS)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_rst_n),
    .i_req     (w_wreq),
    .o_gnt_c   (w_wgnt),
    .o_idx_c   (w_widx),
    .o_valid_c (w_wvld)
  );

  assign gnt_o = w_rgnt | w_wgnt;

  // Port muxes select the granted master's address/data by winning index.
  always_comb begin
    w_raddr = '0;
    w_waddr = '0;
    w_wdata = '0;
    w_wbe   = '0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      if (w_rvld && (w_ridx == rr_ptr_t'(k))) w_raddr = addr_i[k];
      if (w_wvld && (w_widx == rr_ptr_t'(k))) begin
        w_waddr = addr_i[k];
        w_wdata = wdata_i[k];
        w_wbe   = be_i[k];
      end
    end
  end

  register_file_1r_1w_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BYTE   (NUM_BYTE)
  ) u_rf (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .ReadEnable  (w_rvld),
    .ReadAddr    (w_raddr),
    .ReadData    (w_rdata),
    .WriteEnable (w_wvld),
    .WriteAddr   (w_waddr),
    .WriteData   (w_wdata),
    .WriteBE     (w_wbe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvld <= 1'b0;
      r_ridx <= '0;
    end else begin
      r_rvld <= w_rvld;
      r_ridx <= w_ridx;
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      rvalid_o[k] = r_rvld && (r_ridx == rr_ptr_t'(k));
    end
  end

  assign rdata_o = w_rdata;

endmodule

// File: tb/tb_scm_1r1w_rr_arbiter.sv
// Scoreboard bench for scm_1r1w_rr_arbiter: a behavioural arbiter/memory model
// predicts grants each cycle and queues the read response expected next cycle.
module tb_scm_1r1w_rr_arbiter;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NM-1:0]         req, we, gnt, rvalid;
  logic [NM-1:0][AW-1:0] addr;
  logic [NM-1:0][DW-1:0] wdata;
  logic [NM-1:0][NB-1:0] be;
  logic [DW-1:0]         rdata;

  scm_1r1w_rr_arbiter #(
    .NB_MASTERS (NM),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BYTE   (NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata)
  );

  typedef struct packed {
    logic [NM-1:0] vld;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] m_mem [2**AW];
  int            m_rptr, m_wptr;
  logic [DW-1:0] m_rdata;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NM-1:0] r, input int ptr);
    for (int off = 0; off < NM; off++) begin
      int k;
      k = (ptr + off) % NM;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive(input int k, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NB-1:0] b);
    req[k] = r; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  // Called #1 after a rising edge with inputs already applied; ends #1 after the next edge.
  task automatic cycle();
    exp_t          e;
    logic [NM-1:0] eg;
    int            ri, wi;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_eq("rvalid", 64'(rvalid), 64'(e.vld));
      check_eq("rdata", rdata, e.data);
    end
    eg = '0;
    ri = -1;
    wi = -1;
    if (!rst) begin
      ri = pick(req & ~we, m_rptr);
      wi = pick(req & we, m_wptr);
      if (ri >= 0) eg[ri] = 1'b1;
      if (wi >= 0) eg[wi] = 1'b1;
    end
    check_eq("gnt", 64'(gnt), 64'(eg));
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
      m_rptr  = 0;
      m_wptr  = 0;
      m_rdata = '0;
      q.delete();
      e.vld  = '0;
      e.data = '0;
      q.push_back(e);
    end else begin
      e.vld = '0;
      if (ri >= 0) begin
        m_rdata   = m_mem[addr[ri]];
        m_rptr    = (ri + 1) % NM;
        e.vld[ri] = 1'b1;
      end
      e.data = m_rdata;
      q.push_back(e);
      if (wi >= 0) begin
        for (int b = 0; b < NB; b++) begin
          if (be[wi][b]) m_mem[addr[wi]][b*8 +: 8] = wdata[wi][b*8 +: 8];
        end
        m_wptr = (wi + 1) % NM;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    m_rptr = 0; m_wptr = 0; m_rdata = '0;
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    cycle();
    cycle();
    rst = 1'b0;

    // Full write then read by master 1
    drive(1, 1'b1, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF); cycle();
    idle(); drive(1, 1'b1, 1'b0, 5'd3, '0, '0); cycle();
    idle(); cycle();
    check_eq("full_write", rdata, 64'h1122334455667788);

    // Partial write over existing data
    drive(1, 1'b1, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); cycle();
    idle(); drive(1, 1'b1, 1'b0, 5'd3, '0, '0); cycle();
    idle(); cycle();
    check_eq("byte_merge", rdata, 64'h11223344FFFFFFFF);

    // Round-robin of three readers from reset
    rst = 1'b1; idle(); cycle(); rst = 1'b0;
    for (int k = 0; k < NM; k++) drive(k, 1'b1, 1'b0, AW'(k), '0, '0);
    repeat (6) cycle();
    idle(); cycle();

    // Same-address read/write in one cycle returns old data
    drive(1, 1'b1, 1'b1, 5'd5, 64'hA, 8'hFF); cycle();
    idle(); drive(0, 1'b1, 1'b0, 5'd5, '0, '0); drive(2, 1'b1, 1'b1, 5'd5, 64'hB, 8'hFF); cycle();
    idle(); cycle();
    check_eq("old_data", rdata, 64'hA);
    drive(0, 1'b1, 1'b0, 5'd5, '0, '0); cycle();
    idle(); cycle();
    check_eq("new_data", rdata, 64'hB);

    // be=0 write is granted but changes nothing
    drive(2, 1'b1, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00); cycle();
    idle(); drive(0, 1'b1, 1'b0, 5'd5, '0, '0); cycle();
    idle(); cycle();
    check_eq("be_zero", rdata, 64'hB);

    // Sustained write from master 0 alongside two readers
    drive(0, 1'b1, 1'b1, 5'd7, 64'hC0FFEE, 8'hFF);
    drive(1, 1'b1, 1'b0, 5'd5, '0, '0);
    drive(2, 1'b1, 1'b0, 5'd3, '0, '0);
    repeat (6) cycle();
    idle(); cycle();

    // Reset arriving with a pending read
    drive(1, 1'b1, 1'b0, 5'd5, '0, '0); rst = 1'b1; cycle();
    idle(); cycle();
    rst = 1'b0; cycle();
    for (int k = 0; k < NM; k++) drive(k, 1'b1, 1'b0, 5'd5, '0, '0);
    cycle();
    idle(); cycle();
    check_eq("post_reset_rdata", rdata, 64'h0);
    drive(0, 1'b1, 1'b1, 5'd9, 64'h99, 8'hFF);
    drive(1, 1'b1, 1'b1, 5'd10, 64'hAA, 8'hFF);
    drive(2, 1'b1, 1'b0, 5'd3, '0, '0);
    cycle();
    idle(); cycle();

    // Random traffic with occasional reset
    repeat (80) begin
      for (int k = 0; k < NM; k++) begin
        drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              {$urandom, $urandom}, NB'($urandom));
      end
      rst = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rst = 1'b0; idle(); cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scm_1r1w_rr_arbiter.md
Name: scm_1r1w_rr_arbiter

Overview:
- Shares one 1-read/1-write byte-enable latch/BRAM register file (register_file_1r_1w_be) between NB_MASTERS requesters.
- The read port and the write port are arbitrated independently, each with its own round-robin pointer. One read and one write can therefore be granted in the same cycle.
- The block instantiates the register file and returns read data with a per-master valid one cycle after the grant.
- It sits between cluster-side requesters (DMA, accelerator, core) and the shared SCM.

Parameters:
- NB_MASTERS, 3, number of requesters; must be ≥2.
- ADDR_WIDTH, 5, register file address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 64, data width; must be a multiple of 8.
- NUM_BYTE, DATA_WIDTH/8, number of byte enables.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_i  in  NB_MASTERS  per-master request.
- we_i  in  NB_MASTERS  1 = write, 0 = read.
- addr_i  in  NB_MASTERS x ADDR_WIDTH  per-master address.
- wdata_i  in  NB_MASTERS x DATA_WIDTH  per-master write data.
- be_i  in  NB_MASTERS x NUM_BYTE  per-master byte enables; used on writes only.
- gnt_o  out  NB_MASTERS  per-master grant; combinational from req_i.
- rvalid_o  out  NB_MASTERS  read response valid, one-hot.
- rdata_o  out  DATA_WIDTH  read data, shared by all masters; qualified by rvalid_o.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - gnt_o forced to 0 while rst=1.
  - rvalid_o = 0.
  - rdata_o = 0.
  - Both round-robin pointers = 0.
  - The register file reset input is driven by ~rst, so memory contents are cleared to 0.
- Request classes: a read request is req_i[k] & ~we_i[k]; a write request is req_i[k] & we_i[k].
- Arbitration:
  - Each class picks the first requesting master at or after its pointer, in index order with wrap-around (NB_MASTERS-1 wraps to 0).
  - At most one read grant and one write grant per cycle, so gnt_o has at most two bits set.
- Pointer update:
  - On a grant to master k, that class's pointer becomes (k+1) mod NB_MASTERS at the next edge.
  - The pointer is unchanged when nothing is granted. No master can be starved.
- Handshake:
  - A transfer occurs on the cycle where req_i[k] & gnt_o[k] = 1.
  - A master must hold req_i, we_i, addr_i, wdata_i and be_i stable until granted.
  - Ungranted requests have no side effects.
- Write path:
  - The granted write drives WriteEnable=1, WriteAddr, WriteData and WriteBE.
  - Memory updates at the granting edge. Only the bytes with be=1 change; be=0 is a legal no-op write that is still granted.
- Read path:
  - The granted read drives ReadEnable=1 and ReadAddr.
  - The granted index is registered. In the next cycle rvalid_o[index]=1 and rdata_o = register file ReadData.
  - Read latency is exactly 1 cycle. Back-to-back reads are accepted every cycle.
  - With no read grant, ReadEnable=0, so the register file holds its last read data; rvalid_o is 0 regardless.
- Read and write to the same address in the same cycle: the read returns the OLD contents (no bypass). The write is visible from the following read grant onward.
- A master requesting both classes: impossible in one cycle, because we_i selects the class.
- Reset mid-operation: a read granted in the cycle where rst rises produces no rvalid_o. No state survives reset.
- rst=1 suppresses all grants, so no memory write can occur during reset.

Decomposition:
- Package scm_arb_pkg holds:
  - a function for the index width: $clog2(NB_MASTERS), with a minimum of 1;
  - typedef rr_ptr_t for pointer and index signals.
- Natural sub-module: scm_rr_arbiter.
  - Generic one-class round-robin arbiter with inputs req and an advance enable; outputs one-hot gnt and the granted index; owns its own pointer.
  - The top instantiates it twice (read, write), plus register_file_1r_1w_be, the address/data muxes and the rvalid/index register.

Test Plan:
- Reset, then master 1 writes 0x1122334455667788 to addr 3 with be=0xFF. Master 1 then reads addr 3: gnt_o=3'b010 both times; one cycle after the read grant, rvalid_o=3'b010 and rdata_o=0x1122334455667788.
- Write 0xFFFF_FFFF_FFFF_FFFF to addr 3 with be=0x0F over data 0x1122334455667788, then read addr 3 → 0x11223344FFFFFFFF.
- All three masters hold read requests for 6 cycles from reset → grant order 0,1,2,0,1,2; rvalid_o follows one cycle later in the same order.
- Same cycle: master 0 reads addr 5 (contents 0xA) while master 2 writes 0xB to addr 5 → both granted; the read returns 0xA. The next read of addr 5 returns 0xB.
- Master 0 writes while masters 1 and 2 read, all sustained → the write is granted every cycle; reads alternate 1,2,1,2. The write pointer does not affect read order.
- Read granted on the cycle rst is asserted → rvalid_o stays 0 for all following cycles. After release, a read of any address returns 0 and both pointers restart at master 0.
